// File: rtl/regfile_write_arbiter.sv
// Single write-port owner for the 32x32 register file: clears every register
// after reset, then arbitrates ALU writeback (req0) and load unit (req1) round-robin.
module regfile_write_arbiter #(
  parameter int                DATA_W     = 32,
  parameter int                ADDR_W     = 5,
  parameter int                DEPTH      = 32,
  parameter logic [DATA_W-1:0] INIT_VALUE = '0,
  parameter bit                ZERO_REG   = 1'b1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req0_valid,
  input  logic [ADDR_W-1:0] req0_addr,
  input  logic [DATA_W-1:0] req0_data,
  output logic              req0_ready,
  input  logic              req1_valid,
  input  logic [ADDR_W-1:0] req1_addr,
  input  logic [DATA_W-1:0] req1_data,
  output logic              req1_ready,
  output logic [DATA_W-1:0] rf_wd3,
  output logic [ADDR_W-1:0] rf_aw,
  output logic              rf_wr,
  output logic              rf_en,
  output logic              init_done
);

  typedef enum logic {S_INIT, S_RUN} state_t;

  localparam logic [ADDR_W-1:0] LAST_PTR = ADDR_W'(DEPTH - 1);

  state_t            state, state_nxt;
  logic [ADDR_W-1:0] ptr;
  logic              last_grant;
  logic              grant0, grant1;
  logic              xfer0, xfer1, xfer;
  logic [ADDR_W-1:0] sel_addr;
  logic [DATA_W-1:0] sel_data;
  logic              sel_discard;

  always_ff @(posedge clk) begin
    if (rst) state <= S_INIT;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    if (state == S_INIT && ptr == LAST_PTR) state_nxt = S_RUN;
  end

  // On a tie the requester that did not win last time is granted.
  always_comb begin
    grant0 = 1'b0;
    grant1 = 1'b0;
    if (state == S_RUN && !rst) begin
      if (req0_valid && req1_valid) begin
        grant0 = last_grant;
        grant1 = !last_grant;
      end else begin
        grant0 = req0_valid;
        grant1 = req1_valid;
      end
    end
  end

  assign req0_ready  = grant0;
  assign req1_ready  = grant1;
  assign xfer0       = req0_valid && grant0;
  assign xfer1       = req1_valid && grant1;
  assign xfer        = xfer0 || xfer1;
  assign sel_addr    = xfer1 ? req1_addr : req0_addr;
  assign sel_data    = xfer1 ? req1_data : req0_data;
  assign sel_discard = ZERO_REG && (sel_addr == '0);

  // Write-port register stage: one cycle from accept to strobe.
  always_ff @(posedge clk) begin
    if (rst) begin
      ptr        <= '0;
      last_grant <= 1'b1;
      rf_wd3     <= '0;
      rf_aw      <= '0;
      rf_wr      <= 1'b0;
      rf_en      <= 1'b0;
      init_done  <= 1'b0;
    end else begin
      rf_en <= 1'b1;
      if (state == S_INIT) begin
        rf_wr  <= 1'b1;
        rf_aw  <= ptr;
        rf_wd3 <= INIT_VALUE;
        ptr    <= ptr + 1'b1;
        if (ptr == LAST_PTR) init_done <= 1'b1;
      end else begin
        rf_wr <= xfer && !sel_discard;
        if (xfer) begin
          rf_aw      <= sel_addr;
          rf_wd3     <= sel_data;
          last_grant <= xfer1;
        end
      end
    end
  end

endmodule
